// File: rtl/fft_mag_sq_streamer_pkg.sv
// Shared audio types: pop-side state encoding and the default inter-frame gap.
package fft_mag_sq_streamer_pkg;

    localparam int unsigned FRAME_GAP_DEFAULT = 6;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        PAD,
        DROP,
        GAP
    } stream_state_t;

endpackage

// File: rtl/fft_mag_sq_streamer_sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is visible on rdata_o whenever not empty.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 65
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fft_mag_sq_streamer.sv
// Buffers complex FFT bins, repairs frame length to N, streams |x|^2 with a guaranteed inter-frame gap.
module fft_mag_sq_streamer
    import fft_mag_sq_streamer_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned IN_W       = 32,
    parameter int unsigned W          = 64,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FRAME_GAP  = FRAME_GAP_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_re,
    input  logic signed [IN_W-1:0] in_im,
    input  logic                   in_last,
    output logic                   mag_valid,
    output logic [W-1:0]           mag_sq,
    output logic [$clog2(N)-1:0]   bin_index,
    output logic                   frame_start,
    output logic                   frame_err
);
    localparam int unsigned CNT_W = $clog2(N);
    localparam int unsigned PW    = 2 * IN_W;
    localparam int unsigned SW    = PW + 1;
    localparam int unsigned DW    = PW + 1;
    localparam int unsigned GAP_W = $clog2(FRAME_GAP + 1);

    stream_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic [DW-1:0] fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop_c;
    logic          head_last;
    logic signed [IN_W-1:0] head_re;
    logic signed [IN_W-1:0] head_im;

    logic                   iss_v;
    logic                   iss_start;
    logic [CNT_W-1:0]       iss_idx;
    logic signed [IN_W-1:0] iss_re;
    logic signed [IN_W-1:0] iss_im;
    logic signed [PW-1:0]   re_x;
    logic signed [PW-1:0]   im_x;
    logic [PW-1:0]          rr_c;
    logic [PW-1:0]          ii_c;

    logic             s1_v_q, s1_start_q;
    logic [CNT_W-1:0] s1_idx_q;
    logic [PW-1:0]    s1_rr_q, s1_ii_q;
    logic [SW-1:0]    sum_c;
    logic [W-1:0]     mag_c;

    logic             out_v_q, out_start_q;
    logic [CNT_W-1:0] out_idx_q;
    logic [W-1:0]     out_mag_q;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid),
        .pop_i   (pop_c),
        .wdata_i ({in_last, in_re, in_im}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign head_last = fifo_rdata[DW-1];
    assign head_re   = fifo_rdata[DW-2 -: IN_W];
    assign head_im   = fifo_rdata[IN_W-1:0];

    // Pop-side state, bin counter and gap counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    // Next state, FIFO pop, bin issue and frame error detection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        pop_c     = 1'b0;
        iss_v     = 1'b0;
        iss_start = 1'b0;
        iss_idx   = '0;
        iss_re    = '0;
        iss_im    = '0;
        frame_err = 1'b0;
        unique case (state_q)
            IDLE, STREAM: begin
                if (!fifo_empty) begin
                    pop_c     = 1'b1;
                    iss_v     = 1'b1;
                    iss_idx   = cnt_q;
                    iss_start = (cnt_q == '0);
                    iss_re    = head_re;
                    iss_im    = head_im;
                    if (cnt_q == CNT_W'(N - 1)) begin
                        cnt_d   = '0;
                        gap_d   = '0;
                        state_d = head_last ? GAP : DROP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (head_last) begin
                            frame_err = 1'b1;
                            state_d   = PAD;
                        end else begin
                            state_d = STREAM;
                        end
                    end
                end
            end
            PAD: begin
                iss_v   = 1'b1;
                iss_idx = cnt_q;
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d   = '0;
                    gap_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DROP: begin
                if (!fifo_empty) begin
                    pop_c = 1'b1;
                    if (head_last) begin
                        frame_err = 1'b1;
                        gap_d     = '0;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(FRAME_GAP - 1)) begin
                    gap_d   = '0;
                    state_d = fifo_empty ? IDLE : STREAM;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sign-extend before squaring so the most negative input squares correctly.
    assign re_x  = PW'(iss_re);
    assign im_x  = PW'(iss_im);
    assign rr_c  = re_x * re_x;
    assign ii_c  = im_x * im_x;
    assign sum_c = {1'b0, s1_rr_q} + {1'b0, s1_ii_q};

    // Fit the sum into the output width.
    if (SW > W) begin : g_sat
        assign mag_c = (|sum_c[SW-1:W]) ? '1 : sum_c[W-1:0];
    end else begin : g_ext
        assign mag_c = W'(sum_c);
    end

    // Two-stage squarer pipeline carrying bin index and frame start alongside.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q      <= 1'b0;
            s1_start_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_rr_q     <= '0;
            s1_ii_q     <= '0;
            out_v_q     <= 1'b0;
            out_start_q <= 1'b0;
            out_idx_q   <= '0;
            out_mag_q   <= '0;
        end else begin
            s1_v_q      <= iss_v;
            s1_start_q  <= iss_start;
            s1_idx_q    <= iss_idx;
            s1_rr_q     <= rr_c;
            s1_ii_q     <= ii_c;
            out_v_q     <= s1_v_q;
            out_start_q <= s1_start_q;
            out_idx_q   <= s1_idx_q;
            out_mag_q   <= mag_c;
        end
    end

    assign mag_valid   = out_v_q;
    assign mag_sq      = out_mag_q;
    assign bin_index   = out_idx_q;
    assign frame_start = out_start_q;

endmodule

// File: tb/tb_fft_mag_sq_streamer.sv
// Scoreboard bench for fft_mag_sq_streamer: directed frames, monitor compares every output beat.
module tb_fft_mag_sq_streamer;

    localparam int N   = 8;
    localparam int GAP = 6;

    typedef struct {
        logic [63:0] mag;
        logic [2:0]  idx;
        logic        start;
    } exp_t;

    exp_t sb[$];

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic signed [31:0] in_re = '0;
    logic signed [31:0] in_im = '0;
    logic               in_ready;
    logic               mag_valid;
    logic [63:0]        mag_sq;
    logic [2:0]         bin_index;
    logic               frame_start;
    logic               frame_err;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int err_cnt = 0;
    int last_err_cyc = 0;
    int idx_cyc [8];
    bit t5_active = 1'b0;
    int t5_frames = 0;
    bit saw_full = 1'b0;

    logic signed [31:0] t2_re  [8] = '{32'sh8000_0000, 32'sd3, 32'sd1, -32'sd5,
                                       32'sh7FFF_FFFF, 32'sh8000_0000, 32'sd7, -32'sd1};
    logic signed [31:0] t2_im  [8] = '{32'sh8000_0000, 32'sd4, 32'sd1, 32'sd12,
                                       32'sd0, 32'sd0, -32'sd24, -32'sd1};
    logic [63:0]        t2_mag [8] = '{64'h8000_0000_0000_0000, 64'd25, 64'd2, 64'd169,
                                       64'h3FFF_FFFF_0000_0001, 64'h4000_0000_0000_0000,
                                       64'd625, 64'd2};

    fft_mag_sq_streamer dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_re       (in_re),
        .in_im       (in_im),
        .in_last     (in_last),
        .mag_valid   (mag_valid),
        .mag_sq      (mag_sq),
        .bin_index   (bin_index),
        .frame_start (frame_start),
        .frame_err   (frame_err)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1);
    end

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic expect_beat(input logic [63:0] mag, input int idx);
        exp_t e;
        e.mag   = mag;
        e.idx   = 3'(idx);
        e.start = (idx == 0);
        sb.push_back(e);
    endtask

    // Present one beat and return #1 after the edge that accepted it.
    task automatic send(input logic signed [31:0] re, input logic signed [31:0] im, input logic last);
        int t = 0;
        in_re    = re;
        in_im    = im;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 500) chk(1'b0, "ready_timeout", 64'(t), 64'd500);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        chk(sb.size() == 0, "drain", 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (12) @(posedge clk);
        #1;
    endtask

    // Monitor: compares each output beat against the scoreboard and polices frame length / gap.
    initial begin
        exp_t e;
        bit have_prev = 1'b0;
        int beats = 0;
        int idle = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                have_prev = 1'b0;
                beats     = 0;
                idle      = 0;
            end else begin
                if (frame_err) begin
                    err_cnt++;
                    last_err_cyc = cyc;
                end
                if (mag_valid) begin
                    if (frame_start) begin
                        if (have_prev) begin
                            chk(beats == N, "frame_len", 64'(beats), 64'(N));
                            if (t5_active && t5_frames > 0)
                                chk(idle == GAP, "gap_exact", 64'(idle), 64'(GAP));
                            else
                                chk(idle >= GAP, "gap_min", 64'(idle), 64'(GAP));
                        end
                        if (t5_active) t5_frames++;
                        beats = 0;
                    end
                    beats++;
                    idx_cyc[bin_index] = cyc;
                    if (int'(bin_index) == N - 1) begin
                        have_prev = 1'b1;
                        idle      = 0;
                    end
                    if (sb.size() == 0) begin
                        chk(1'b0, "unexpected_beat", mag_sq, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk(mag_sq == e.mag, "beat_mag", mag_sq, e.mag);
                        chk(bin_index == e.idx, "beat_idx", 64'(bin_index), 64'(e.idx));
                        chk(frame_start == e.start, "beat_start", 64'(frame_start), 64'(e.start));
                    end
                end else begin
                    idle++;
                end
                if (t5_active && !in_ready) saw_full = 1'b1;
            end
        end
    end

    initial begin
        int p;
        int err0;
        bit found;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk(mag_valid == 1'b0, "rst_mag_valid", 64'(mag_valid), 64'd0);
        chk(mag_sq == 64'd0, "rst_mag_sq", mag_sq, 64'd0);
        chk(bin_index == 3'd0, "rst_bin_index", 64'(bin_index), 64'd0);
        chk(frame_start == 1'b0, "rst_frame_start", 64'(frame_start), 64'd0);
        chk(frame_err == 1'b0, "rst_frame_err", 64'(frame_err), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);

        // 1: re=k, im=-k -> 2k^2, with latency measured on bin 0
        expect_beat(64'd0, 0);
        send(32'sd0, 32'sd0, 1'b0);
        p = cyc;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (mag_valid) found = 1'b1;
        end
        chk(found && (cyc - p) == 2, "latency", 64'(cyc - p), 64'd2);
        for (int k = 1; k < N; k++) begin
            expect_beat(64'(2 * k * k), k);
            send(32'(k), 32'(-k), k == N - 1);
        end
        drain();

        // 2: extreme and small magnitudes
        for (int k = 0; k < N; k++) begin
            expect_beat(t2_mag[k], k);
            send(t2_re[k], t2_im[k], k == N - 1);
        end
        drain();

        // 3: short frame of 5 bins is padded with zeros
        err0 = err_cnt;
        for (int k = 0; k < 5; k++) begin
            expect_beat(64'((k + 1) * (k + 1) + 4), k);
            send(32'(k + 1), 32'sd2, k == 4);
        end
        for (int k = 5; k < N; k++) expect_beat(64'd0, k);
        drain();
        chk(err_cnt - err0 == 1, "short_err_count", 64'(err_cnt - err0), 64'd1);
        chk(idx_cyc[4] - last_err_cyc == 2, "short_err_align", 64'(idx_cyc[4] - last_err_cyc), 64'd2);

        // 4: long frame of 11 bins is truncated to 8
        err0 = err_cnt;
        for (int k = 0; k < 11; k++) begin
            if (k < N) expect_beat(64'((10 + k) * (10 + k)), k);
            send(32'(10 + k), 32'sd0, k == 10);
        end
        drain();
        chk(err_cnt - err0 == 1, "long_err_count", 64'(err_cnt - err0), 64'd1);

        // 5: back-to-back frames with continuous in_valid
        err0 = err_cnt;
        t5_active = 1'b1;
        for (int f = 0; f < 7; f++) begin
            for (int k = 0; k < N; k++) begin
                expect_beat(64'((f * 8 + k + 1) * (f * 8 + k + 1) + 9), k);
                send(32'(f * 8 + k + 1), -32'sd3, k == N - 1);
            end
        end
        drain();
        t5_active = 1'b0;
        chk(saw_full, "in_ready_dropped", 64'(saw_full), 64'd1);
        chk(t5_frames == 7, "b2b_frames", 64'(t5_frames), 64'd7);
        chk(err_cnt == err0, "b2b_no_err", 64'(err_cnt - err0), 64'd0);

        // 6: reset while bin 4 is on the output
        err0 = err_cnt;
        fork
            begin
                for (int k = 0; k < N; k++) begin
                    expect_beat(64'((k + 2) * (k + 2) + k * k), k);
                    in_re    = 32'(k + 2);
                    in_im    = 32'(k);
                    in_last  = (k == N - 1);
                    in_valid = 1'b1;
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            begin
                found = 1'b0;
                for (int i = 0; i < 50 && !found; i++) begin
                    @(negedge clk);
                    if (mag_valid && bin_index == 3'd4) found = 1'b1;
                end
                chk(found, "rst_bin4_seen", 64'(found), 64'd1);
                reset = 1'b1;
                @(posedge clk);
                #1;
                chk(mag_valid == 1'b0, "midrst_mag_valid", 64'(mag_valid), 64'd0);
                chk(mag_sq == 64'd0, "midrst_mag_sq", mag_sq, 64'd0);
                chk(bin_index == 3'd0, "midrst_bin_index", 64'(bin_index), 64'd0);
                chk(frame_start == 1'b0, "midrst_frame_start", 64'(frame_start), 64'd0);
                chk(frame_err == 1'b0, "midrst_frame_err", 64'(frame_err), 64'd0);
                chk(in_ready == 1'b1, "midrst_in_ready", 64'(in_ready), 64'd1);
                sb.delete();
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
        join
        repeat (20) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            expect_beat(64'(k * k + 1), k);
            send(32'(k), 32'sd1, k == N - 1);
        end
        drain();
        chk(err_cnt == err0, "rst_no_err", 64'(err_cnt - err0), 64'd0);

        chk(sb.size() == 0, "sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
